add_round_key_seq: RTL and testbench

ADD_ROUND_KEY_SEQ -- requirements
Module: add_round_key_seq

---
 rtl/add_round_key_seq.sv | 136 +++++++++++++
 tb/tb_add_round_key_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_seq.sv
// add_round_key_seq
//   Sequential AES AddRoundKey. A key/state pair is captured on a ready/valid
//   handshake. LANES bytes of (state XOR key) are then written into state_out
//   on each RUN cycle. The finished result is held until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   key/state offered            in_ready   block can accept (IDLE only)
//   key        round key, byte i at [i*WORD_SIZE +: WORD_SIZE]
//   state      state, column-major (row = i mod 4, column = i div 4)
//   out_valid  state_out holds a result     out_ready  consumer accepts the result
//   state_out  result, same byte order as state
//   busy       high in RUN or HOLD          done       one-cycle pulse after hand-off
module add_round_key_seq #(
    parameter int WORD_SIZE     = 8,
    parameter int NC            = 4,
    parameter int LANES         = 4,
    parameter int KEY_ROW_MAJOR = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_SIZE*4*NC-1:0] key,
    input  logic [WORD_SIZE*4*NC-1:0] state,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_SIZE*4*NC-1:0] state_out,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned W      = WORD_SIZE;
    localparam int unsigned NCU    = NC;
    localparam int unsigned LN     = LANES;
    localparam int unsigned BYTES  = 4 * NCU;
    localparam int unsigned BITS   = W * BYTES;
    localparam int unsigned BEATS  = BYTES / LN;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } fsm_e;

    fsm_e              fsm_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BITS-1:0]   key_q;
    logic [BITS-1:0]   st_q;
    logic [BITS-1:0]   state_out_q;
    logic [BITS-1:0]   state_out_d;
    logic [BITS-1:0]   key_eff;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;

    // A row-major key is reordered into the state's column-major layout:
    // effective byte j (row j%4, column j/4) comes from key byte row*NC + column.
    always_comb begin
        key_eff = key;
        if (KEY_ROW_MAJOR != 0) begin
            for (int unsigned j = 0; j < BYTES; j++) begin
                key_eff[j*W +: W] = key[((j % 4) * NCU + j / 4) * W +: W];
            end
        end
    end

    // Only the lanes of the current beat change; all other bytes keep their value.
    always_comb begin
        state_out_d = state_out_q;
        for (int unsigned l = 0; l < LN; l++) begin
            int unsigned idx;
            idx = 32'(beat_q) * LN + l;
            state_out_d[idx*W +: W] = st_q[idx*W +: W] ^ key_q[idx*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            beat_q      <= '0;
            key_q       <= '0;
            st_q        <= '0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        key_q      <= key_eff;
                        st_q       <= state;
                        beat_q     <= '0;
                        fsm_q      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    state_out_q <= state_out_d;
                    beat_q      <= beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        fsm_q       <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq
//   Drives eight add_round_key_seq instances (NC 4/6/8, several LANES and key
//   orders) from one shared key/state bus, one at a time. Results are compared
//   against a byte-array AddRoundKey reference model.
module tb_add_round_key_seq;

    function automatic int cfg_nc(input int g);
        case (g)
            0, 1:    return 4;
            2, 3, 4: return 6;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_lanes(input int g);
        case (g)
            0, 1, 3, 6: return 4;
            2, 5:       return 1;
            4:          return 24;
            default:    return 32;
        endcase
    endfunction

    function automatic int cfg_krm(input int g);
        if (g == 0) return 0;
        if (g == 1) return 1;
        return g % 2;
    endfunction

    function automatic int cfg_beats(input int g);
        return 4 * cfg_nc(g) / cfg_lanes(g);
    endfunction

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       in_valid_v = '0;
    logic [7:0]       out_ready_v = '0;
    logic [7:0]       in_ready_v;
    logic [7:0]       out_valid_v;
    logic [7:0]       busy_v;
    logic [7:0]       done_v;
    logic [255:0]     key_w = '0;
    logic [255:0]     state_w = '0;
    logic [7:0][255:0] so_a;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        localparam int GNC = cfg_nc(g);
        localparam int GL  = cfg_lanes(g);
        localparam int GK  = cfg_krm(g);
        localparam int GB  = 8 * 4 * GNC;
        add_round_key_seq #(
            .WORD_SIZE    (8),
            .NC           (GNC),
            .LANES        (GL),
            .KEY_ROW_MAJOR(GK)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_v[g]),
            .in_ready (in_ready_v[g]),
            .key      (key_w[GB-1:0]),
            .state    (state_w[GB-1:0]),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready_v[g]),
            .state_out(so_a[g][GB-1:0]),
            .busy     (busy_v[g]),
            .done     (done_v[g])
        );
        if (GB < 256) begin : g_pad
            assign so_a[g][255:GB] = '0;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: out[row,col] = state[row,col] ^ key[row,col]; a row-major key
    // stores (row,col) at row*NC+col, a column-major one at col*4+row.
    function automatic logic [255:0] model(input int g, input logic [255:0] k,
                                           input logic [255:0] s);
        logic [255:0] r;
        int nc, j, kb;
        r  = '0;
        nc = cfg_nc(g);
        for (int c = 0; c < nc; c++) begin
            for (int row = 0; row < 4; row++) begin
                j  = c * 4 + row;
                kb = (cfg_krm(g) != 0) ? row * nc + c : j;
                r[j*8 +: 8] = s[j*8 +: 8] ^ k[kb*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rev16(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = x[(15-i)*8 +: 8];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one transaction on instance g: returns the result and the number of
    // edges from the accepting edge to the first out_valid, then consumes it.
    task automatic txn(input int g, input logic [255:0] k, input logic [255:0] s,
                       output logic [255:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready_v[g] && w < 50) begin @(posedge clk); #1; w++; end
        check("ready_wait", 256'(in_ready_v[g]), 256'd1);
        key_w = k; state_w = s; in_valid_v[g] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[g] = 1'b0;
        lat = 0;
        while (!out_valid_v[g] && lat < 200) begin @(posedge clk); #1; lat++; end
        res = so_a[g];
        out_ready_v[g] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[g] = 1'b0;
        check("done_pulse", 256'(done_v[g]), 256'd1);
        check("ready_after", 256'(in_ready_v[g]), 256'd1);
        check("ovalid_clear", 256'(out_valid_v[g]), 256'd0);
    endtask

    task automatic b2b(input int g, input int nres);
        logic [255:0] exp_q[$];
        logic [255:0] e;
        int got, cyc, last;
        got = 0; cyc = 0; last = -1;
        in_valid_v[g] = 1'b1;
        out_ready_v[g] = 1'b1;
        while (got < nres && cyc < 500) begin
            key_w = rand256(); state_w = rand256();
            if (in_ready_v[g]) exp_q.push_back(model(g, key_w, state_w));
            @(posedge clk); #1;
            cyc++;
            if (out_valid_v[g]) begin
                check("b2b_pending", 256'(exp_q.size() > 0), 256'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_result", so_a[g], e);
                end
                if (last >= 0) check("b2b_period", 256'(cyc - last), 256'(cfg_beats(g) + 2));
                last = cyc;
                got++;
            end
        end
        check("b2b_count", 256'(got), 256'(nres));
        in_valid_v[g] = 1'b0;
        out_ready_v[g] = 1'b0;
        do_reset();
    endtask

    initial begin
        logic [255:0] res, held, k, s;
        int lat;

        // reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 256'(in_ready_v), 256'hff);
        check("rst_out_valid", 256'(out_valid_v), 256'd0);
        check("rst_busy", 256'(busy_v), 256'd0);
        check("rst_done", 256'(done_v), 256'd0);
        check("rst_state_out0", so_a[0], 256'd0);
        check("rst_state_out7", so_a[7], 256'd0);

        // FIPS-197 round-0 vector, column-major key
        txn(0, {128'd0, rev16(128'h2b7e151628aed2a6abf7158809cf4f3c)},
               {128'd0, rev16(128'h3243f6a8885a308d313198a2e0370734)}, res, lat);
        check("fips_result", res, {128'd0, rev16(128'h193de3bea0f4e22b9ac68d2ae9f84808)});
        check("fips_latency", 256'(lat), 256'd4);
        check("hold_after_done", so_a[0], {128'd0, rev16(128'h193de3bea0f4e22b9ac68d2ae9f84808)});

        // key transpose
        txn(1, {128'd0, 128'h0f0e0d0c0b0a09080706050403020100}, 256'd0, res, lat);
        check("transpose", res, {128'd0, 128'h0f0b07030e0a06020d0905010c080400});
        check("transpose_lat", 256'(lat), 256'd4);

        // backpressure in HOLD
        k = rand256(); s = rand256();
        key_w = k; state_w = s; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (!out_valid_v[0] && lat < 50) begin @(posedge clk); #1; lat++; end
        check("bp_latency", 256'(lat), 256'd4);
        held = so_a[0];
        check("bp_result", held, model(0, k, s));
        for (int i = 0; i < 10; i++) begin
            key_w = rand256(); state_w = rand256(); in_valid_v[0] = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 256'(out_valid_v[0]), 256'd1);
            check("bp_state_out", so_a[0], held);
            check("bp_in_ready", 256'(in_ready_v[0]), 256'd0);
            check("bp_busy", 256'(busy_v[0]), 256'd1);
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        check("bp_done", 256'(done_v[0]), 256'd1);
        check("bp_ready_after", 256'(in_ready_v[0]), 256'd1);
        @(posedge clk); #1;
        check("bp_done_once", 256'(done_v[0]), 256'd0);
        check("bp_no_accept", so_a[0], held);

        // reset while RUN is at beat 2
        key_w = rand256(); state_w = rand256(); in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rrun_out_valid", 256'(out_valid_v[0]), 256'd0);
        check("rrun_state_out", so_a[0], 256'd0);
        check("rrun_in_ready", 256'(in_ready_v[0]), 256'd1);
        check("rrun_busy", 256'(busy_v[0]), 256'd0);
        for (int i = 0; i < 6; i++) begin
            check("rrun_no_done", 256'(done_v[0]), 256'd0);
            check("rrun_no_valid", 256'(out_valid_v[0]), 256'd0);
            @(posedge clk); #1;
        end

        // parameter sweep
        for (int g = 2; g < 8; g++) begin
            for (int t = 0; t < 3; t++) begin
                k = rand256(); s = rand256();
                txn(g, k, s, res, lat);
                check($sformatf("sweep%0d_result", g), res, model(g, k, s));
                check($sformatf("sweep%0d_latency", g), 256'(lat), 256'(cfg_beats(g)));
            end
        end

        // back-to-back streaming
        b2b(0, 4);
        b2b(4, 4);
        b2b(5, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
